pe_load_sequencer: RTL

Clocked sequencer that drives a PE's load-split stage. For each job it merges a filter source stream and an ifmap source stream into the single `{data, ifmapb_filter, filter_row}` word stream the split stage consumes. Each job sends exactly five filter rows, tagged row 1..5, then a programmed number of ifmap windows. It sits between the PE's upstream packet decoder and the load-split stage, and is the only writer of that stage's inputs.

---
 rtl/pe_pkg.sv | 29 ++
 rtl/pe_out_reg.sv | 61 ++++++
 rtl/pe_load_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the PE load path: sequencer state encoding, filter
//   row-tag constants and the ifmap/filter flag encoding seen by the split
//   stage.
// -----------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILT  = 2'd1,
        IFM   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam int NUM_FILTER_ROWS = 5;

    // Row tags carried with each output word; 0 marks an ifmap word.
    localparam logic [2:0] ROW_NONE = 3'd0;
    localparam logic [2:0] ROW1     = 3'd1;
    localparam logic [2:0] ROW2     = 3'd2;
    localparam logic [2:0] ROW3     = 3'd3;
    localparam logic [2:0] ROW4     = 3'd4;
    localparam logic [2:0] ROW5     = 3'd5;

    localparam logic IFMAPB_IFMAP  = 1'b0;
    localparam logic IFMAPB_FILTER = 1'b1;

endpackage

// File: rtl/pe_out_reg.sv
// -----------------------------------------------------------------------------
// pe_out_reg
//   Single-entry valid/ready output register for the load sequencer. Holds one
//   {data, ifmap/filter flag, row tag} word until the consumer takes it.
//
// Ports
//   i_clk, i_rst    clock, synchronous active-high reset (empties the entry)
//   i_load          write a new word this cycle (caller guarantees space)
//   i_data/i_flag/i_row   word to be written
//   i_out_ready     consumer ready
//   o_valid         entry occupied
//   o_data/o_flag/o_row   held word, stable while o_valid & !i_out_ready
// -----------------------------------------------------------------------------
module pe_out_reg
    import pe_pkg::*;
#(
    parameter int DW = 40
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_flag,
    input  logic [2:0]    i_row,
    input  logic          i_out_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_flag,
    output logic [2:0]    o_row
);

    logic          r_vld_p1;
    logic [DW-1:0] r_data_p1;
    logic          r_flag_p1;
    logic [2:0]    r_row_p1;

    // ---- stage p1: output holding register ----
    // A load may coincide with the consumer taking the old word; the new
    // word simply replaces it, which is what gives one word per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_flag_p1 <= IFMAPB_IFMAP;
            r_row_p1  <= ROW_NONE;
        end else if (i_load) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= i_data;
            r_flag_p1 <= i_flag;
            r_row_p1  <= i_row;
        end else if (i_out_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign o_valid = r_vld_p1;
    assign o_data  = r_data_p1;
    assign o_flag  = r_flag_p1;
    assign o_row   = r_row_p1;

endmodule

// File: rtl/pe_load_sequencer.sv
// -----------------------------------------------------------------------------
// pe_load_sequencer
//   Drives the PE load-split stage. Per job it forwards exactly five filter
//   rows (tagged 1..5) from the filter source, then num_windows ifmap words
//   (tag 0) from the ifmap source, through a single-entry output register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, num_windows       job start (accepted in IDLE only), window count
//   busy, done               job in progress, single-cycle end-of-job pulse
//   filt_valid/ready/data    filter row source
//   ifm_valid/ready/data     ifmap window source (data passed through as-is)
//   out_valid/ready          output handshake to the split stage
//   out_data, out_ifmapb_filter, out_filter_row   output word fields
//   stall_cycles             (PE_SEQ_STALL_CNT_EN only) saturating count of
//                            busy cycles with the output held by backpressure
//
// Build option: define PE_SEQ_STALL_CNT_EN to add the stall counter.
// -----------------------------------------------------------------------------
module pe_load_sequencer #(
    parameter int FILTER_WIDTH = 8,
    parameter int NUM_ROWS     = 5,
    parameter int WIN_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIN_W-1:0]          num_windows,
    output logic                      busy,
    output logic                      done,
    input  logic                      filt_valid,
    output logic                      filt_ready,
    input  logic [5*FILTER_WIDTH-1:0] filt_data,
    input  logic                      ifm_valid,
    output logic                      ifm_ready,
    input  logic [5*FILTER_WIDTH-1:0] ifm_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5*FILTER_WIDTH-1:0] out_data,
    output logic                      out_ifmapb_filter,
    output logic [2:0]                out_filter_row
`ifdef PE_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cycles
`endif
);

    import pe_pkg::*;

    localparam int               DW       = 5 * FILTER_WIDTH;
    localparam logic [2:0]       ROW_LAST = 3'(NUM_ROWS);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    seq_state_t       r_state;
    logic [2:0]       r_row_cnt;
    logic [WIN_W-1:0] r_win_left;

    logic          w_load_en;
    logic          w_filt_hs;
    logic          w_ifm_hs;
    logic          w_load;
    logic [DW-1:0] w_in_data;
    logic          w_in_flag;
    logic [2:0]    w_in_row;
    logic          w_done;

    // ---- stage p0: source selection and handshakes ----
    // Readies depend only on state and out_ready (through load_en), never on
    // a source valid, so no valid->ready combinational path exists.
    always_comb begin
        w_load_en  = !out_valid || out_ready;
        filt_ready = (r_state == FILT) && w_load_en;
        ifm_ready  = (r_state == IFM)  && w_load_en;
        w_filt_hs  = filt_valid && filt_ready;
        w_ifm_hs   = ifm_valid  && ifm_ready;
        w_load     = w_filt_hs  || w_ifm_hs;

        if (r_state == FILT) begin
            w_in_data = filt_data;
            w_in_flag = IFMAPB_FILTER;
            w_in_row  = r_row_cnt;
        end else begin
            w_in_data = ifm_data;
            w_in_flag = IFMAPB_IFMAP;
            w_in_row  = ROW_NONE;
        end

        // Job ends once the last word has left (or is leaving) the register.
        w_done = (r_state == DRAIN) && w_load_en;
        done   = w_done;
        busy   = (r_state != IDLE) && !w_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_row_cnt  <= ROW_NONE;
            r_win_left <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_win_left <= num_windows;
                        r_row_cnt  <= ROW1;
                        r_state    <= FILT;
                    end
                end
                FILT: begin
                    if (w_filt_hs) begin
                        if (r_row_cnt == ROW_LAST) begin
                            r_state <= (r_win_left != '0) ? IFM : DRAIN;
                        end else begin
                            r_row_cnt <= r_row_cnt + 3'd1;
                        end
                    end
                end
                IFM: begin
                    // win_left is >= 1 here, so the decrement cannot wrap.
                    if (w_ifm_hs) begin
                        r_win_left <= r_win_left - WIN_ONE;
                        if (r_win_left == WIN_ONE) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: output register ----
    pe_out_reg #(
        .DW (DW)
    ) u_out_reg (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (w_load),
        .i_data      (w_in_data),
        .i_flag      (w_in_flag),
        .i_row       (w_in_row),
        .i_out_ready (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_flag      (out_ifmapb_filter),
        .o_row       (out_filter_row)
    );

`ifdef PE_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (busy && out_valid && !out_ready) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
